lif_neuron_tile: RTL and testbench
==================================

// Module: lif_neuron_tile
// PURPOSE
//  Parametrised leaky integrate-and-fire neuron; next-generation tile for the neurochip array.
//  N_DEND weighted dendrites feed a saturating membrane register (U), with a selectable decay line.
//  Adds three things: a configurable firing threshold, a refractory period and a disable state.
//  Configuration is a serial bit-stream chain (bs_in -> bs_out), so tiles daisy-chain across the array.
// PARAMETERS
//  N_DEND   3  number of dendritic inputs
//  W_WT     3  weight width per dendrite (unsigned)
//  W_U      5  membrane / threshold width (unsigned)
//  N_DECAY  8  width of decay bus; TSEL_W = $clog2(N_DECAY)
//  REFRAC_W 2  refractory-count width
//  CFG_LEN = N_DEND*W_WT + TSEL_W + W_U + REFRAC_W (derived; 19 at defaults)
// PORTS
//  clk       in   1         clock; all state updates on posedge
//  rst_n     in   1         asynchronous active-low reset
//  conf_en   in   1         1 = shift config chain; neuron held idle
//  nn_reset  in   1         synchronous neuron clear (config kept)
//  bs_in     in   1         config serial in
//  bs_out    out  1         config serial out = cfg[CFG_LEN-1]
//  dend      in   N_DEND    dendrite spikes, dend[i] gates weight w[i]
//  dBus      in   N_DECAY   shared decay-clock bus
//  axon      out  1         registered spike, 1-cycle pulse
//  u_mon     out  W_U       current membrane value U
//  refrac    out  1         1 while refractory counter nonzero
// BEHAVIOUR
//  Reset (rst_n=0, async): cfg=0, U=0, rcnt=0, axon=0 -> bs_out=0, u_mon=0, refrac=0.
//  cfg layout MSB..LSB: {rp[REFRAC_W], thr[W_U], tsel[TSEL_W], w[N_DEND-1]..w[0]}.
//  Priority per edge: conf_en > nn_reset > run.
//  conf_en=1: cfg <= {cfg[CFG_LEN-2:0], bs_in}; U, rcnt, axon <= 0.
//    Chain delay bs_in->bs_out is exactly CFG_LEN cycles.
//  nn_reset=1 (conf_en=0): U, rcnt, axon <= 0; cfg unchanged.
//  Run (both 0):
//    u_l  = dBus[tsel] ? U>>1 : U. Leak applies before integration.
//           tsel >= N_DECAY reads as 0 (no leak).
//    sum  = u_l + SUM_i(dend[i] ? w[i] : 0).
//           Internal width must hold the max value without wrap; it is never truncated.
//    u_s  = min(sum, 2^W_U-1). Saturate, never wrap.
//    thr==0: tile disabled. U<=0, axon<=0, rcnt<=0.
//    rcnt!=0: U<=0, axon<=0, rcnt<=rcnt-1. Dendrites and leak are ignored.
//    else if u_s>=thr: axon<=1, U<=0, rcnt<=rp.
//    else: axon<=0, U<=u_s.
//  Timing:
//    Spike latency: axon is high for the cycle after the edge where u_s crosses thr.
//    With rp=R, the next accumulation starts R cycles after the firing edge.
//    Minimum spike period is R+1.
//  axon always clears after one cycle; there are no back-to-back spikes unless rp=0 and thr<=sum of active weights.
//  Async reset mid-run or mid-shift aborts immediately and loses the config (thr=0 -> disabled).
// TESTING
//  1 w0=3, w1=w2=0, tsel=0, thr=10, rp=0, dBus=0, dend=001 held
//    -> U=3,6,9; axon=1 after edge 4 (U=0); period 4.
//  2 Config as in 1 but tsel=2, dBus[2]=1 held
//    -> U=3,4,5,5,5...; axon never asserts.
//  3 w0=3, thr=3, rp=2, dend=001 held
//    -> axon at edges 1, 4, 7; refrac=1 for 2 cycles after each spike.
//  4 All w=7, thr=31, dend=111, no leak
//    -> U=21, then sum 42 saturates to 31 >= thr; axon after edge 2.
//  5 Shift a 19-bit pattern, then 19 zeros with conf_en=1
//    -> bs_out replays the pattern 19 cycles late; U=0 and axon=0 throughout.
//  6 rst_n low mid-accumulation (U=9)
//    -> u_mon=0 and axon=0 without a clk edge; after release no spikes occur (thr=0).

Source files
------------

// File: rtl/lif_neuron_tile.sv
// Leaky integrate-and-fire neuron tile: weighted dendrites, selectable leak, threshold,
// refractory period and a daisy-chained serial configuration register.
module lif_neuron_tile #(
  parameter int N_DEND   = 3,
  parameter int W_WT     = 3,
  parameter int W_U      = 5,
  parameter int N_DECAY  = 8,
  parameter int REFRAC_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               conf_en,
  input  logic               nn_reset,
  input  logic               bs_in,
  output logic               bs_out,
  input  logic [N_DEND-1:0]  dend,
  input  logic [N_DECAY-1:0] dBus,
  output logic               axon,
  output logic [W_U-1:0]     u_mon,
  output logic               refrac
);

  localparam int TSEL_W  = (N_DECAY > 1) ? $clog2(N_DECAY) : 1;
  localparam int CFG_LEN = N_DEND*W_WT + TSEL_W + W_U + REFRAC_W;
  localparam int MAX_SUM = (2**W_U - 1) + N_DEND*(2**W_WT - 1);
  localparam int SUM_W   = $clog2(MAX_SUM + 1);
  localparam logic [W_U-1:0] U_MAX = {W_U{1'b1}};

  logic [CFG_LEN-1:0]  cfg_q, cfg_d;
  logic [W_U-1:0]      u_q, u_d;
  logic [REFRAC_W-1:0] rcnt_q, rcnt_d;
  logic                axon_q, axon_d;

  logic [TSEL_W-1:0]   tsel;
  logic [W_U-1:0]      thr;
  logic [REFRAC_W-1:0] rp;
  logic                leakSel;
  logic [W_U-1:0]      uLeak;
  logic [SUM_W-1:0]    sum;
  logic [W_U-1:0]      uSat;

  assign tsel = cfg_q[N_DEND*W_WT +: TSEL_W];
  assign thr  = cfg_q[N_DEND*W_WT + TSEL_W +: W_U];
  assign rp   = cfg_q[CFG_LEN-1 -: REFRAC_W];

  // Leak first, then integrate; an out-of-range tsel selects no decay line.
  always_comb begin
    leakSel = 1'b0;
    for (int i = 0; i < N_DECAY; i++) begin
      if (int'(tsel) == i) leakSel = dBus[i];
    end
    uLeak = leakSel ? (u_q >> 1) : u_q;
    sum = SUM_W'(uLeak);
    for (int i = 0; i < N_DEND; i++) begin
      if (dend[i]) sum = sum + SUM_W'(cfg_q[i*W_WT +: W_WT]);
    end
    uSat = (sum > SUM_W'(U_MAX)) ? U_MAX : sum[W_U-1:0];
  end

  always_comb begin
    cfg_d  = cfg_q;
    u_d    = u_q;
    rcnt_d = rcnt_q;
    axon_d = 1'b0;
    if (conf_en) begin
      cfg_d  = {cfg_q[CFG_LEN-2:0], bs_in};
      u_d    = '0;
      rcnt_d = '0;
    end else if (nn_reset || thr == '0) begin
      u_d    = '0;
      rcnt_d = '0;
    end else if (rcnt_q != '0) begin
      u_d    = '0;
      rcnt_d = rcnt_q - REFRAC_W'(1);
    end else if (uSat >= thr) begin
      axon_d = 1'b1;
      u_d    = '0;
      rcnt_d = rp;
    end else begin
      u_d = uSat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q  <= '0;
      u_q    <= '0;
      rcnt_q <= '0;
      axon_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      u_q    <= u_d;
      rcnt_q <= rcnt_d;
      axon_q <= axon_d;
    end
  end

  assign bs_out = cfg_q[CFG_LEN-1];
  assign axon   = axon_q;
  assign u_mon  = u_q;
  assign refrac = |rcnt_q;

endmodule

// File: tb/tb_lif_neuron_tile.sv
// Directed-vector bench for lif_neuron_tile at default parameters (CFG_LEN = 19).
module tb_lif_neuron_tile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       conf_en;
  logic       nn_reset;
  logic       bs_in;
  logic       bs_out;
  logic [2:0] dend;
  logic [7:0] dBus;
  logic       axon;
  logic [4:0] u_mon;
  logic       refrac;

  int checkCount = 0;
  int passCount  = 0;

  lif_neuron_tile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .conf_en  (conf_en),
    .nn_reset (nn_reset),
    .bs_in    (bs_in),
    .bs_out   (bs_out),
    .dend     (dend),
    .dBus     (dBus),
    .axon     (axon),
    .u_mon    (u_mon),
    .refrac   (refrac)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Layout {rp, thr, tsel, w2, w1, w0}; MSB is shifted in first.
  function automatic logic [18:0] makeCfg(input logic [2:0] w0, input logic [2:0] w1,
                                          input logic [2:0] w2, input logic [2:0] tsel,
                                          input logic [4:0] thr, input logic [1:0] rp);
    return {rp, thr, tsel, w2, w1, w0};
  endfunction

  task automatic loadConfig(input logic [18:0] cfgWord);
    dend    = 3'b000;
    conf_en = 1'b1;
    for (int i = 18; i >= 0; i--) begin
      bs_in = cfgWord[i];
      stepCycle();
    end
    conf_en = 1'b0;
    bs_in   = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] d, input logic [7:0] db);
    dend = d;
    dBus = db;
  endtask

  initial begin
    int expU[8];
    int expA[8];
    int expR[7];
    logic [18:0] pat;

    rst_n = 1'b0; conf_en = 1'b0; nn_reset = 1'b0; bs_in = 1'b0;
    dend = 3'b000; dBus = 8'h00;
    #12;
    checkOutput("reset u_mon", u_mon, 0);
    checkOutput("reset axon", axon, 0);
    checkOutput("reset bs_out", bs_out, 0);
    checkOutput("reset refrac", refrac, 0);
    rst_n = 1'b1;
    stepCycle();

    // Test 1: w0=3, thr=10, no leak -> period 4
    loadConfig(makeCfg(3'd3, 3'd0, 3'd0, 3'd0, 5'd10, 2'd0));
    applyStimulus(3'b001, 8'h00);
    expU = '{3, 6, 9, 0, 3, 6, 9, 0};
    expA = '{0, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkOutput($sformatf("t1 u e%0d", i + 1), u_mon, expU[i]);
      checkOutput($sformatf("t1 axon e%0d", i + 1), axon, expA[i]);
    end
    stepCycle();
    stepCycle();
    checkOutput("t1 pre-clear u", u_mon, 6);
    nn_reset = 1'b1;
    stepCycle();
    checkOutput("nn_reset u", u_mon, 0);
    nn_reset = 1'b0;
    stepCycle();
    checkOutput("nn_reset cfg kept u", u_mon, 3);

    // Test 2: leak on decay line 2 -> settles at 5, never fires
    loadConfig(makeCfg(3'd3, 3'd0, 3'd0, 3'd2, 5'd10, 2'd0));
    applyStimulus(3'b001, 8'b0000_0100);
    expU = '{3, 4, 5, 5, 5, 5, 5, 5};
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkOutput($sformatf("t2 u e%0d", i + 1), u_mon, expU[i]);
      checkOutput($sformatf("t2 axon e%0d", i + 1), axon, 0);
    end

    // Test 3: thr=3 reached exactly, rp=2 -> spikes every 3 edges
    loadConfig(makeCfg(3'd3, 3'd0, 3'd0, 3'd0, 5'd3, 2'd2));
    applyStimulus(3'b001, 8'h00);
    expA[0:6] = '{1, 0, 0, 1, 0, 0, 1};
    expR      = '{1, 1, 0, 1, 1, 0, 1};
    for (int i = 0; i < 7; i++) begin
      stepCycle();
      checkOutput($sformatf("t3 axon e%0d", i + 1), axon, expA[i]);
      checkOutput($sformatf("t3 refrac e%0d", i + 1), refrac, expR[i]);
      checkOutput($sformatf("t3 u e%0d", i + 1), u_mon, 0);
    end

    // Test 4: all weights 7, thr=31 -> 21, then saturated 31 fires
    loadConfig(makeCfg(3'd7, 3'd7, 3'd7, 3'd0, 5'd31, 2'd0));
    applyStimulus(3'b111, 8'h00);
    stepCycle();
    checkOutput("t4 u e1", u_mon, 21);
    checkOutput("t4 axon e1", axon, 0);
    stepCycle();
    checkOutput("t4 axon e2", axon, 1);
    checkOutput("t4 u e2", u_mon, 0);
    stepCycle();
    checkOutput("t4 axon e3", axon, 0);
    checkOutput("t4 u e3", u_mon, 21);

    // Test 5: chain replay with neuron held idle
    pat = 19'h5A3C7;
    applyStimulus(3'b111, 8'h00);
    conf_en = 1'b1;
    for (int i = 18; i >= 0; i--) begin
      bs_in = pat[i];
      stepCycle();
      checkOutput($sformatf("t5 load u %0d", i), u_mon, 0);
      checkOutput($sformatf("t5 load axon %0d", i), axon, 0);
    end
    checkOutput("t5 bs_out 0", bs_out, pat[18]);
    for (int k = 1; k <= 19; k++) begin
      bs_in = 1'b0;
      stepCycle();
      checkOutput($sformatf("t5 bs_out %0d", k), bs_out, (k < 19) ? pat[18 - k] : 1'b0);
      checkOutput($sformatf("t5 axon %0d", k), axon, 0);
    end
    conf_en = 1'b0;

    // Test 6: async reset mid-accumulation loses config
    loadConfig(makeCfg(3'd3, 3'd0, 3'd0, 3'd0, 5'd10, 2'd0));
    applyStimulus(3'b001, 8'h00);
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("t6 u before reset", u_mon, 9);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async u", u_mon, 0);
    checkOutput("t6 async axon", axon, 0);
    checkOutput("t6 async bs_out", bs_out, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkOutput($sformatf("t6 post u e%0d", i + 1), u_mon, 0);
      checkOutput($sformatf("t6 post axon e%0d", i + 1), axon, 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
